cube_scan_sequencer: RTL and testbench

// - Parametrised plane/colour scan engine for the LED cube's 74HC595 chains.
// - Per slot (plane p, colour c): fetch a column word from external frame ROM, shift it on the control chain,

---
 rtl/cube_scan_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_cube_scan_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cube_scan_sequencer
//  Purpose  : Plane/colour scan engine for the LED cube's 74HC595 chains.
//             For every slot (plane p, colour c) it fetches a column word
//             from an external registered frame ROM and shifts it MSB first
//             onto the control chain. At the same time it shifts a one-hot
//             plane select onto the colour-c chain, with all other colour
//             chains inactive. It then pulses the global storage latch,
//             dwells, and advances to the next slot. Two frame banks are
//             supported; a bank swap is requested with bank_req and is
//             taken only at a frame boundary.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    state_clk   in   scan clock, all logic on the rising edge
//    reset       in   synchronous, active-high
//    enable      in   run scanning; a slot in progress always completes
//    rom_addr    out  bank*PLANES*COLORS + plane*COLORS + color
//    rom_data    in   ROM word, valid one cycle after rom_addr
//    ctrl_ds     out  control chain serial data
//    ctrl_shcp   out  control chain shift clock
//    color_ds    out  per-colour chain serial data
//    color_shcp  out  shared colour chain shift clock (equals ctrl_shcp)
//    stcp        out  global storage latch, one-cycle pulse per slot
//    mr_n        out  global master reset, active-low
//    plane       out  current plane index
//    color       out  current colour index
//    frame_done  out  one-cycle pulse in the last cycle of a frame
//    bank_req    in   bank swap request (level, held until bank_ack)
//    bank_ack    out  one-cycle pulse when the swap is taken
//    oe_n        out  output blank, present only with CUBE_SCAN_BLANK_EN;
//                     low only while dwelling
//  Configuration macro
//    CUBE_SCAN_BLANK_EN : adds the oe_n output
// ============================================================================
module cube_scan_sequencer #(
  parameter int   DATA_WIDTH = 8,
  parameter int   PLANES     = 7,
  parameter int   COLORS     = 3,
  parameter int   DWELL      = 4,
  parameter logic COLOR_POL  = 1'b1,
  parameter int   ADDR_W     = $clog2(2*PLANES*COLORS)
) (
  input  logic                  state_clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  ctrl_ds,
  output logic                  ctrl_shcp,
  output logic [COLORS-1:0]     color_ds,
  output logic                  color_shcp,
  output logic                  stcp,
  output logic                  mr_n,
  output logic [2:0]            plane,
  output logic [1:0]            color,
  output logic                  frame_done,
  input  logic                  bank_req,
  output logic                  bank_ack
`ifdef CUBE_SCAN_BLANK_EN
  ,
  output logic                  oe_n
`endif
);

  localparam int c_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int c_DW_W  = $clog2(DWELL + 1);

  localparam logic [c_BIT_W-1:0] c_BIT_MSB    = c_BIT_W'(DATA_WIDTH - 1);
  localparam logic [c_DW_W-1:0]  c_DWELL_LOAD = c_DW_W'(DWELL - 1);
  localparam logic [2:0]         c_PLANE_LAST = 3'(PLANES - 1);
  localparam logic [1:0]         c_COLOR_LAST = 2'(COLORS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DWELL = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_fetch_cnt;   // 0: address cycle, 1: capture cycle
  logic [c_BIT_W-1:0]    r_bit;         // index of the bit currently on DS
  logic                  r_phase;       // 0: SHCP low, 1: SHCP high
  logic [DATA_WIDTH-1:0] r_shift;       // captured column word
  logic [c_DW_W-1:0]     r_dwell_cnt;   // counts down to 0 in DWELL
  logic                  r_bank;

  logic                  w_last_slot;
  logic                  w_enter_final_dwell;
  logic [2:0]            w_next_plane;
  logic [1:0]            w_next_color;
  logic [c_BIT_W-1:0]    w_bit_dn;

  // Colour chain bit k for the current slot: active only on the chain of the
  // current colour and only at the position of the current plane.
  function automatic logic [COLORS-1:0] col_bits(input logic [c_BIT_W-1:0] k,
                                                 input logic [2:0]         p,
                                                 input logic [1:0]         c);
    logic [COLORS-1:0] res;
    for (int i = 0; i < COLORS; i++) begin
      res[i] = ((int'(k) == int'(p)) && (i == int'(c))) ? COLOR_POL : ~COLOR_POL;
    end
    return res;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic       b,
                                                input logic [2:0] p,
                                                input logic [1:0] c);
    return ADDR_W'(int'(b) * PLANES * COLORS + int'(p) * COLORS + int'(c));
  endfunction

  always_comb begin
    w_last_slot  = (plane == c_PLANE_LAST) && (color == c_COLOR_LAST);
    w_bit_dn     = r_bit - c_BIT_W'(1);
    w_next_color = color + 2'd1;
    w_next_plane = plane;
    if (color == c_COLOR_LAST) begin
      w_next_color = 2'd0;
      w_next_plane = (plane == c_PLANE_LAST) ? 3'd0 : plane + 3'd1;
    end
    // True on the edge that enters the final DWELL cycle of a slot. Frame-end
    // signalling is raised there so that it coincides with the last cycle.
    w_enter_final_dwell = ((r_state == S_LATCH) && (c_DWELL_LOAD == '0)) ||
                          ((r_state == S_DWELL) && (r_dwell_cnt == c_DW_W'(1)));
  end

  always_ff @(posedge state_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_fetch_cnt <= 1'b0;
      r_bit       <= '0;
      r_phase     <= 1'b0;
      r_shift     <= '0;
      r_dwell_cnt <= '0;
      r_bank      <= 1'b0;
      plane       <= 3'd0;
      color       <= 2'd0;
      rom_addr    <= '0;
      ctrl_ds     <= 1'b0;
      ctrl_shcp   <= 1'b0;
      color_ds    <= '0;
      color_shcp  <= 1'b0;
      stcp        <= 1'b0;
      mr_n        <= 1'b0;
      frame_done  <= 1'b0;
      bank_ack    <= 1'b0;
`ifdef CUBE_SCAN_BLANK_EN
      oe_n        <= 1'b1;
`endif
    end else begin
      mr_n       <= 1'b1;
      frame_done <= 1'b0;
      bank_ack   <= 1'b0;

      // The bank flips here, one edge before the slot advance, so the
      // address computed at the advance already points into the new bank.
      if (w_enter_final_dwell && w_last_slot) begin
        frame_done <= 1'b1;
        if (bank_req) begin
          r_bank   <= ~r_bank;
          bank_ack <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state     <= S_FETCH;
            r_fetch_cnt <= 1'b0;
          end
        end

        S_FETCH: begin
          if (!r_fetch_cnt) begin
            // rom_addr is already stable; the ROM registers it on this edge.
            r_fetch_cnt <= 1'b1;
          end else begin
            r_state    <= S_SHIFT;
            r_shift    <= rom_data;
            r_bit      <= c_BIT_MSB;
            r_phase    <= 1'b0;
            ctrl_ds    <= rom_data[DATA_WIDTH-1];
            color_ds   <= col_bits(c_BIT_MSB, plane, color);
            ctrl_shcp  <= 1'b0;
            color_shcp <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (!r_phase) begin
            // Rising shift clock; data stays put for the whole high phase.
            r_phase    <= 1'b1;
            ctrl_shcp  <= 1'b1;
            color_shcp <= 1'b1;
          end else if (r_bit == '0) begin
            r_state    <= S_LATCH;
            ctrl_shcp  <= 1'b0;
            color_shcp <= 1'b0;
            ctrl_ds    <= 1'b0;
            color_ds   <= '0;
            stcp       <= 1'b1;
          end else begin
            r_bit      <= w_bit_dn;
            r_phase    <= 1'b0;
            ctrl_shcp  <= 1'b0;
            color_shcp <= 1'b0;
            ctrl_ds    <= r_shift[w_bit_dn];
            color_ds   <= col_bits(w_bit_dn, plane, color);
          end
        end

        S_LATCH: begin
          stcp        <= 1'b0;
          r_state     <= S_DWELL;
          r_dwell_cnt <= c_DWELL_LOAD;
`ifdef CUBE_SCAN_BLANK_EN
          oe_n        <= 1'b0;
`endif
        end

        S_DWELL: begin
          if (r_dwell_cnt != '0) begin
            r_dwell_cnt <= r_dwell_cnt - c_DW_W'(1);
          end else begin
            // Slot complete: advance indices even if enable has dropped, so
            // a later resume continues with the following slot.
            plane       <= w_next_plane;
            color       <= w_next_color;
            rom_addr    <= addr_of(r_bank, w_next_plane, w_next_color);
            r_fetch_cnt <= 1'b0;
            r_state     <= enable ? S_FETCH : S_IDLE;
`ifdef CUBE_SCAN_BLANK_EN
            oe_n        <= 1'b1;
`endif
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cube_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cube_scan_sequencer
//  Purpose  : Directed self-checking bench for cube_scan_sequencer at the
//             default parameters (8-bit words, 7 planes, 3 colours, dwell 4,
//             23-cycle slots, 483-cycle frames). A registered ROM model
//             serves rom_data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cube_scan_sequencer;

  localparam int DW   = 8;
  localparam int PL   = 7;
  localparam int CO   = 3;
  localparam int AW   = 6;
  localparam int SLOT = 23;
  localparam int FRAME = PL * CO * SLOT;   // 483

  logic          state_clk = 1'b0;
  logic          reset     = 1'b1;
  logic          enable    = 1'b0;
  logic          bank_req  = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          ctrl_ds, ctrl_shcp, color_shcp, stcp, mr_n;
  logic [CO-1:0] color_ds;
  logic [2:0]    plane;
  logic [1:0]    color;
  logic          frame_done, bank_ack;
`ifdef CUBE_SCAN_BLANK_EN
  logic          oe_n;
`endif

  cube_scan_sequencer dut (
    .state_clk (state_clk),
    .reset     (reset),
    .enable    (enable),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ctrl_ds   (ctrl_ds),
    .ctrl_shcp (ctrl_shcp),
    .color_ds  (color_ds),
    .color_shcp(color_shcp),
    .stcp      (stcp),
    .mr_n      (mr_n),
    .plane     (plane),
    .color     (color),
    .frame_done(frame_done),
    .bank_req  (bank_req),
    .bank_ack  (bank_ack)
`ifdef CUBE_SCAN_BLANK_EN
    ,
    .oe_n      (oe_n)
`endif
  );

  always #5 state_clk = ~state_clk;

  logic [DW-1:0] rom_mem [0:63];
  always @(posedge state_clk) rom_data <= rom_mem[rom_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic tick();
    @(posedge state_clk);
    #1;
    cyc++;
  endtask

  // Reset, one idle cycle, then enable; cycle 0 is the IDLE cycle whose
  // closing edge samples enable, so stcp of slot s falls in cycle 19+23*s.
  task automatic start_scan();
    reset = 1'b1; enable = 1'b0; bank_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    enable = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; bank_req = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({ctrl_ds, ctrl_shcp, color_ds, color_shcp, stcp, frame_done, bank_ack} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0", {ctrl_ds, ctrl_shcp, color_ds, color_shcp, stcp, frame_done, bank_ack});
    end
    n_cmp++;
    if (mr_n !== 1'b0) begin n_bad++; $display("FAIL reset_mr_n: got %b want 0", mr_n); end
    n_cmp++;
    if ({plane, color} !== 5'd0) begin n_bad++; $display("FAIL reset_indices: got %0d/%0d want 0/0", plane, color); end
    n_cmp++;
    if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
`ifdef CUBE_SCAN_BLANK_EN
    n_cmp++;
    if (oe_n !== 1'b1) begin n_bad++; $display("FAIL reset_oe_n: got %b want 1", oe_n); end
`endif
    reset = 1'b0;
    tick();
    n_cmp++;
    if (mr_n !== 1'b1) begin n_bad++; $display("FAIL mr_n_release: got %b want 1", mr_n); end
    repeat (4) tick();
    n_cmp++;
    if ({ctrl_shcp, stcp} !== 2'b00) begin n_bad++; $display("FAIL idle_quiet: got %b want 00", {ctrl_shcp, stcp}); end
  endtask

  // Full first frame: A5 word, per-slot words, one-hot plane selects,
  // addresses, stcp timing and the single frame_done.
  task automatic test_scan_frame();
    logic          prev_shcp;
    logic [DW-1:0] cw;
    logic [DW-1:0] kw [CO];
    logic [DW-1:0] exp_k;
    int nb, slot, fd_cnt, fd_cyc, ack_seen, shcp_diff;
    prev_shcp = 1'b0; cw = '0; nb = 0; slot = 0;
    fd_cnt = 0; fd_cyc = -1; ack_seen = 0; shcp_diff = 0;
    for (int c = 0; c < CO; c++) kw[c] = '0;
    start_scan();
    while (cyc < FRAME + 1) begin
      tick();
      if (ctrl_shcp !== color_shcp) shcp_diff++;
      if (ctrl_shcp && !prev_shcp) begin
        cw = {cw[DW-2:0], ctrl_ds};
        for (int c = 0; c < CO; c++) kw[c] = {kw[c][DW-2:0], color_ds[c]};
        nb++;
      end
      prev_shcp = ctrl_shcp;
      if (bank_ack) ack_seen++;
      if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
      if (stcp) begin
        n_cmp++;
        if (cyc != 19 + SLOT * slot) begin n_bad++; $display("FAIL stcp_cycle slot %0d: got %0d want %0d", slot, cyc, 19 + SLOT * slot); end
        n_cmp++;
        if (nb != DW) begin n_bad++; $display("FAIL shcp_rises slot %0d: got %0d want %0d", slot, nb, DW); end
        n_cmp++;
        if (rom_addr !== AW'(slot)) begin n_bad++; $display("FAIL rom_addr slot %0d: got %0d want %0d", slot, rom_addr, slot); end
        n_cmp++;
        if (int'(plane) != slot / CO || int'(color) != slot % CO) begin
          n_bad++; $display("FAIL indices slot %0d: got %0d/%0d want %0d/%0d", slot, plane, color, slot / CO, slot % CO);
        end
        n_cmp++;
        if (cw !== rom_mem[slot]) begin n_bad++; $display("FAIL ctrl_word slot %0d: got %h want %h", slot, cw, rom_mem[slot]); end
        if (slot == 0) begin
          n_cmp++;
          if (cw !== 8'hA5) begin n_bad++; $display("FAIL ctrl_a5_bits: got %b want 10100101", cw); end
        end
        if (slot == 7) begin
          n_cmp++;
          if ({kw[2], kw[1], kw[0]} !== {8'h00, 8'b0000_0100, 8'h00}) begin
            n_bad++; $display("FAIL plane2_color1: got %b %b %b want 00000000 00000100 00000000", kw[2], kw[1], kw[0]);
          end
        end
        for (int c = 0; c < CO; c++) begin
          exp_k = (c == slot % CO) ? 8'(1 << (slot / CO)) : 8'h00;
          n_cmp++;
          if (kw[c] !== exp_k) begin n_bad++; $display("FAIL color_word slot %0d chain %0d: got %b want %b", slot, c, kw[c], exp_k); end
        end
        slot++; nb = 0;
      end
    end
    n_cmp++;
    if (slot != PL * CO) begin n_bad++; $display("FAIL slot_count: got %0d want %0d", slot, PL * CO); end
    n_cmp++;
    if (fd_cnt != 1 || fd_cyc != FRAME) begin n_bad++; $display("FAIL frame_done: got %0d pulses at %0d want 1 at %0d", fd_cnt, fd_cyc, FRAME); end
    n_cmp++;
    if (ack_seen != 0) begin n_bad++; $display("FAIL no_req_ack: got %0d want 0", ack_seen); end
    n_cmp++;
    if ({plane, color} !== 5'd0 || rom_addr !== 6'd0) begin
      n_bad++; $display("FAIL frame_wrap: got %0d/%0d addr %0d want 0/0 addr 0", plane, color, rom_addr);
    end
    n_cmp++;
    if (shcp_diff != 0) begin n_bad++; $display("FAIL shcp_equal: got %0d differing cycles want 0", shcp_diff); end
  endtask

  // Continues from the end of the first frame with no reset in between.
  task automatic test_bank_swap();
    logic          prev_shcp;
    logic [DW-1:0] cw;
    int ack_cnt, ack_cyc, fd_cyc, max_addr, addr_after, stcp_after;
    logic [DW-1:0] word_after;
    prev_shcp = 1'b0; cw = '0; ack_cnt = 0; ack_cyc = -1; fd_cyc = -1;
    max_addr = 0; addr_after = -1; stcp_after = -1; word_after = '0;
    while (cyc < 2 * FRAME + 30) begin
      tick();
      if (cyc == FRAME + 117) bank_req = 1'b1;
      if (ctrl_shcp && !prev_shcp) cw = {cw[DW-2:0], ctrl_ds};
      prev_shcp = ctrl_shcp;
      if (ack_cyc < 0 && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (frame_done && fd_cyc < 0) fd_cyc = cyc;
      if (bank_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = cyc;
        bank_req = 1'b0;
      end
      if (stcp && ack_cyc >= 0 && addr_after < 0) begin
        addr_after = int'(rom_addr); word_after = cw; stcp_after = cyc;
      end
    end
    n_cmp++;
    if (max_addr > 20) begin n_bad++; $display("FAIL early_swap: got max addr %0d want <=20", max_addr); end
    n_cmp++;
    if (ack_cnt != 1 || ack_cyc != 2 * FRAME) begin n_bad++; $display("FAIL bank_ack: got %0d pulses at %0d want 1 at %0d", ack_cnt, ack_cyc, 2 * FRAME); end
    n_cmp++;
    if (fd_cyc != 2 * FRAME) begin n_bad++; $display("FAIL frame2_done: got %0d want %0d", fd_cyc, 2 * FRAME); end
    n_cmp++;
    if (addr_after != 21) begin n_bad++; $display("FAIL swap_addr: got %0d want 21", addr_after); end
    n_cmp++;
    if (word_after !== rom_mem[21]) begin n_bad++; $display("FAIL swap_word: got %h want %h", word_after, rom_mem[21]); end
    n_cmp++;
    if (stcp_after != 2 * FRAME + 19) begin n_bad++; $display("FAIL swap_stcp_cycle: got %0d want %0d", stcp_after, 2 * FRAME + 19); end
  endtask

  task automatic test_reset_mid_shift();
    int stcp_cnt, stcp_cyc, stcp_addr;
    start_scan();
    while (cyc < 11) tick();          // cycle 11: bit 3 on DS, SHCP low
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({ctrl_ds, ctrl_shcp, color_ds, color_shcp, stcp, mr_n, frame_done, bank_ack} !== 10'b0) begin
      n_bad++; $display("FAIL midreset_outputs: got %b want 0", {ctrl_ds, ctrl_shcp, color_ds, color_shcp, stcp, mr_n, frame_done, bank_ack});
    end
    n_cmp++;
    if ({plane, color} !== 5'd0 || rom_addr !== 6'd0) begin
      n_bad++; $display("FAIL midreset_indices: got %0d/%0d addr %0d want 0/0 addr 0", plane, color, rom_addr);
    end
    stcp_cnt = 0;
    repeat (10) begin tick(); if (stcp) stcp_cnt++; end
    n_cmp++;
    if (stcp_cnt != 0) begin n_bad++; $display("FAIL midreset_no_stcp: got %0d want 0", stcp_cnt); end
    reset = 1'b0;                     // enable still high
    cyc = 0; stcp_cyc = -1; stcp_addr = -1;
    while (cyc < 25) begin
      tick();
      if (stcp && stcp_cyc < 0) begin stcp_cyc = cyc; stcp_addr = int'(rom_addr); end
    end
    n_cmp++;
    if (stcp_cyc != 19 || stcp_addr != 0) begin
      n_bad++; $display("FAIL restart_slot0: got stcp at %0d addr %0d want 19 addr 0", stcp_cyc, stcp_addr);
    end
  endtask

  task automatic test_enable_drop();
    int stcp_cnt, stcp_cyc, late_shcp, oe_err, r_cyc, r_addr;
    start_scan();
    while (cyc < 5) tick();
    enable = 1'b0;
    stcp_cnt = 0; stcp_cyc = -1; late_shcp = 0; oe_err = 0;
    while (cyc < 60) begin
      tick();
      if (stcp) begin stcp_cnt++; stcp_cyc = cyc; end
      if (cyc > 23 && ctrl_shcp) late_shcp++;
`ifdef CUBE_SCAN_BLANK_EN
      if (oe_n !== ((cyc >= 20 && cyc <= 23) ? 1'b0 : 1'b1)) oe_err++;
`endif
    end
    n_cmp++;
    if (stcp_cnt != 1 || stcp_cyc != 19) begin n_bad++; $display("FAIL drop_slot_completes: got %0d stcp at %0d want 1 at 19", stcp_cnt, stcp_cyc); end
    n_cmp++;
    if (late_shcp != 0) begin n_bad++; $display("FAIL drop_idle: got %0d shcp cycles want 0", late_shcp); end
    n_cmp++;
    if (plane !== 3'd0 || color !== 2'd1 || rom_addr !== 6'd1) begin
      n_bad++; $display("FAIL drop_advance: got %0d/%0d addr %0d want 0/1 addr 1", plane, color, rom_addr);
    end
`ifdef CUBE_SCAN_BLANK_EN
    n_cmp++;
    if (oe_err != 0) begin n_bad++; $display("FAIL oe_n_dwell_only: got %0d bad cycles want 0", oe_err); end
`endif
    enable = 1'b1;
    cyc = 0; r_cyc = -1; r_addr = -1;
    while (cyc < 25) begin
      tick();
      if (stcp && r_cyc < 0) begin r_cyc = cyc; r_addr = int'(rom_addr); end
    end
    n_cmp++;
    if (r_cyc != 19 || r_addr != 1) begin n_bad++; $display("FAIL resume: got stcp at %0d addr %0d want 19 addr 1", r_cyc, r_addr); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'((i * 29 + 60) ^ (i << 3));
    rom_mem[0] = 8'hA5;
    test_reset();
    test_scan_frame();
    test_bank_swap();
    test_reset_mid_shift();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
